// File: rtl/ddram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddram_arb_pkg
//   Shared types and constants for the two-port DDRAM arbiter.
//   - arb_state_t : command-path FSM states (IDLE / write-burst lock)
//   - arb_tag_t   : read tag {owner, len} queued per accepted read command
//   - PORT_CPU / PORT_VID : port identifiers used as owner / grant values
//   The tag length field is TAG_LEN_W bits wide; the arbiter's BCW parameter
//   must not exceed it.
// ----------------------------------------------------------------------------
package ddram_arb_pkg;

    localparam int TAG_LEN_W = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_VID = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_WRBURST
    } arb_state_t;

    typedef struct packed {
        logic                 owner;
        logic [TAG_LEN_W-1:0] len;
    } arb_tag_t;

endpackage

// File: rtl/ddram_arb_tagfifo.sv
// ----------------------------------------------------------------------------
// ddram_arb_tagfifo
//   Synchronous FIFO of read tags, DEPTH entries (power of two, >= 2).
//   Ports:
//     clk_sys, reset   clock, asynchronous active-high reset (empties FIFO)
//     push, din        write a tag (ignored while full)
//     pop              drop the head tag (ignored while empty)
//     head             current head tag (valid when !empty)
//     full, empty      status flags, derived from registered pointers only
// ----------------------------------------------------------------------------
module ddram_arb_tagfifo
    import ddram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_sys,
    input  logic     reset,
    input  logic     push,
    input  arb_tag_t din,
    input  logic     pop,
    output arb_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    arb_tag_t        mem [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk_sys) begin
        if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/ddram_arbiter.sv
// ----------------------------------------------------------------------------
// ddram_arbiter
//   Shares one 64-bit Avalon-MM burst master toward DDRAM between port 0
//   (CPU/cache path) and port 1 (video/HPS fill path). Commands are forwarded
//   combinationally; write bursts lock the owner until the last beat; read
//   data is steered back through an in-order tag FIFO.
//
//   Build option: define DDRAM_ARB_RR_EN for round-robin arbitration; when
//   undefined, port 0 always wins contention and no pointer register exists.
//
//   Ports:
//     clk_sys, reset            clock, asynchronous active-high reset
//     mN_address/read/write/    Avalon slave side for requester N (0/1)
//     writedata/byteenable/
//     burstcount
//     mN_waitrequest            stall toward requester N
//     mN_readdata/readdatavalid read return toward requester N
//     ddram_*                   Avalon master side toward the DDRAM bridge
// ----------------------------------------------------------------------------
module ddram_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int AW      = 29,
    parameter int BCW     = 8,
    parameter int MAXPEND = 4
) (
    input  logic           clk_sys,
    input  logic           reset,

    input  logic [AW-1:0]  m0_address,
    input  logic           m0_read,
    input  logic           m0_write,
    input  logic [63:0]    m0_writedata,
    input  logic [7:0]     m0_byteenable,
    input  logic [BCW-1:0] m0_burstcount,
    output logic           m0_waitrequest,
    output logic [63:0]    m0_readdata,
    output logic           m0_readdatavalid,

    input  logic [AW-1:0]  m1_address,
    input  logic           m1_read,
    input  logic           m1_write,
    input  logic [63:0]    m1_writedata,
    input  logic [7:0]     m1_byteenable,
    input  logic [BCW-1:0] m1_burstcount,
    output logic           m1_waitrequest,
    output logic [63:0]    m1_readdata,
    output logic           m1_readdatavalid,

    output logic [AW-1:0]  ddram_address,
    output logic           ddram_read,
    output logic           ddram_write,
    output logic [63:0]    ddram_writedata,
    output logic [7:0]     ddram_byteenable,
    output logic [BCW-1:0] ddram_burstcount,
    input  logic           ddram_waitrequest,
    input  logic [63:0]    ddram_readdata,
    input  logic           ddram_readdatavalid
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t     state_q, state_d;
    logic           owner_q, owner_d;
    logic [BCW-1:0] beats_left_q, beats_left_d;
    logic [BCW-1:0] head_cnt_q;

    logic           req0, req1;
    logic           prio_port;
    logic           grant;
    logic           sel_read, sel_write;
    logic [BCW-1:0] sel_bc, sel_len;
    logic           rd_fwd, wr_fwd;
    logic           rd_acc, wr_acc;
    logic           sel_wait;

    arb_tag_t       push_tag, head_tag;
    logic           fifo_full, fifo_empty;
    logic           ret_valid, head_last, tag_pop;
    logic [BCW-1:0] head_len;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef DDRAM_ARB_RR_EN
    logic rr_ptr_q;

    // The loser of the last accepted IDLE command gets priority next time.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= PORT_CPU;
        end else if (state_q == ST_IDLE && (rd_acc || wr_acc)) begin
            rr_ptr_q <= ~grant;
        end
    end

    assign prio_port = rr_ptr_q;
`else
    assign prio_port = PORT_CPU;
`endif

    // ------------------------------------------------------------------
    // Grant selection: locked owner during a write burst, otherwise the
    // single requester or the priority port under contention.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant = PORT_CPU;
        if (state_q == ST_WRBURST) begin
            grant = owner_q;
        end else if (req0 && req1) begin
            grant = prio_port;
        end else if (req1) begin
            grant = PORT_VID;
        end
    end

    assign sel_read  = (grant == PORT_VID) ? m1_read       : m0_read;
    assign sel_write = (grant == PORT_VID) ? m1_write      : m0_write;
    assign sel_bc    = (grant == PORT_VID) ? m1_burstcount : m0_burstcount;
    assign sel_len   = (sel_bc == '0) ? BCW'(1) : sel_bc;

    // Reads are only launched from IDLE and only while a tag slot is free;
    // the full flag is registered, so a same-cycle pop cannot free a slot.
    assign rd_fwd = !reset && (state_q == ST_IDLE) && sel_read && !fifo_full;
    assign wr_fwd = !reset && sel_write;
    assign rd_acc = rd_fwd && !ddram_waitrequest;
    assign wr_acc = wr_fwd && !ddram_waitrequest;

    // A granted port whose command is not forwarded is stalled.
    assign sel_wait = !(rd_fwd || wr_fwd) || ddram_waitrequest;

    assign m0_waitrequest = (grant == PORT_CPU) ? sel_wait : 1'b1;
    assign m1_waitrequest = (grant == PORT_VID) ? sel_wait : 1'b1;

    assign ddram_read       = rd_fwd;
    assign ddram_write      = wr_fwd;
    assign ddram_address    = (grant == PORT_VID) ? m1_address    : m0_address;
    assign ddram_writedata  = (grant == PORT_VID) ? m1_writedata  : m0_writedata;
    assign ddram_byteenable = (grant == PORT_VID) ? m1_byteenable : m0_byteenable;
    assign ddram_burstcount = sel_bc;

    // ------------------------------------------------------------------
    // Write-burst FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc && sel_len != BCW'(1)) begin
                    state_d      = ST_WRBURST;
                    owner_d      = grant;
                    beats_left_d = sel_len - BCW'(1);
                end
            end
            ST_WRBURST: begin
                if (wr_acc) begin
                    beats_left_d = beats_left_q - BCW'(1);
                    if (beats_left_q == BCW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_CPU;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
        end
    end

    // ------------------------------------------------------------------
    // Read tags and return routing
    // ------------------------------------------------------------------
    assign push_tag.owner = grant;
    assign push_tag.len   = TAG_LEN_W'(sel_len);

    ddram_arb_tagfifo #(
        .DEPTH (MAXPEND)
    ) u_tagfifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (rd_acc),
        .din     (push_tag),
        .pop     (tag_pop),
        .head    (head_tag),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Beats arriving with no tag outstanding are dropped.
    assign ret_valid = !reset && ddram_readdatavalid && !fifo_empty;
    assign head_len  = BCW'(head_tag.len);
    assign head_last = (head_cnt_q == head_len - BCW'(1));
    assign tag_pop   = ret_valid && head_last;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            head_cnt_q <= '0;
        end else if (ret_valid) begin
            head_cnt_q <= head_last ? '0 : head_cnt_q + BCW'(1);
        end
    end

    assign m0_readdata      = ddram_readdata;
    assign m1_readdata      = ddram_readdata;
    assign m0_readdatavalid = ret_valid && (head_tag.owner == PORT_CPU);
    assign m1_readdatavalid = ret_valid && (head_tag.owner == PORT_VID);

endmodule

// File: tb/tb_ddram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddram_arbiter
//   Directed bench for ddram_arbiter. Inputs change on the falling edge and
//   outputs are compared 1 time unit later; the DUT registers on the rising
//   edge. Expected read-return owners are queued when a read is accepted and
//   popped as DDRAM beats are returned.
// ----------------------------------------------------------------------------
module tb_ddram_arbiter;

    localparam int AW  = 29;
    localparam int BCW = 8;

    logic           clk_sys;
    logic           reset;

    logic [AW-1:0]  m0_address, m1_address;
    logic           m0_read, m0_write, m1_read, m1_write;
    logic [63:0]    m0_writedata, m1_writedata;
    logic [7:0]     m0_byteenable, m1_byteenable;
    logic [BCW-1:0] m0_burstcount, m1_burstcount;
    logic           m0_waitrequest, m1_waitrequest;
    logic [63:0]    m0_readdata, m1_readdata;
    logic           m0_readdatavalid, m1_readdatavalid;

    logic [AW-1:0]  ddram_address;
    logic           ddram_read, ddram_write;
    logic [63:0]    ddram_writedata;
    logic [7:0]     ddram_byteenable;
    logic [BCW-1:0] ddram_burstcount;
    logic           ddram_waitrequest;
    logic [63:0]    ddram_readdata;
    logic           ddram_readdatavalid;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    ddram_arbiter #(.AW(AW), .BCW(BCW), .MAXPEND(4)) dut (
        .clk_sys             (clk_sys),
        .reset               (reset),
        .m0_address          (m0_address),
        .m0_read             (m0_read),
        .m0_write            (m0_write),
        .m0_writedata        (m0_writedata),
        .m0_byteenable       (m0_byteenable),
        .m0_burstcount       (m0_burstcount),
        .m0_waitrequest      (m0_waitrequest),
        .m0_readdata         (m0_readdata),
        .m0_readdatavalid    (m0_readdatavalid),
        .m1_address          (m1_address),
        .m1_read             (m1_read),
        .m1_write            (m1_write),
        .m1_writedata        (m1_writedata),
        .m1_byteenable       (m1_byteenable),
        .m1_burstcount       (m1_burstcount),
        .m1_waitrequest      (m1_waitrequest),
        .m1_readdata         (m1_readdata),
        .m1_readdatavalid    (m1_readdatavalid),
        .ddram_address       (ddram_address),
        .ddram_read          (ddram_read),
        .ddram_write         (ddram_write),
        .ddram_writedata     (ddram_writedata),
        .ddram_byteenable    (ddram_byteenable),
        .ddram_burstcount    (ddram_burstcount),
        .ddram_waitrequest   (ddram_waitrequest),
        .ddram_readdata      (ddram_readdata),
        .ddram_readdatavalid (ddram_readdatavalid)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; return-data strobe is one cycle wide.
    task automatic cyc();
        @(negedge clk_sys);
        ddram_readdatavalid = 1'b0;
    endtask

    // Return one DDRAM read beat and compare routing against the scoreboard.
    task automatic ret_beat(input logic [63:0] d);
        bit e;
        cyc();
        ddram_readdatavalid = 1'b1;
        ddram_readdata      = d;
        #1;
        if (exp_q.size() == 0) begin
            check("rdv_unexpected", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("rdv_port0", {63'd0, m0_readdatavalid}, {63'd0, e == 1'b0});
            check("rdv_port1", {63'd0, m1_readdatavalid}, {63'd0, e == 1'b1});
            check("rdata", e ? m1_readdata : m0_readdata, d);
        end
    endtask

    // Write-burst stimulus table: {write, ddram_waitrequest} per cycle.
    logic [1:0] wr_tab [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                2'b00, 2'b11, 2'b10, 2'b10, 2'b10};

    initial begin
        logic g;
        int   beat;

        reset = 1'b1;
        m0_address = '0; m1_address = '0;
        m0_read = 1'b1; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = 8'hFF; m1_byteenable = 8'hFF;
        m0_burstcount = 8'd1; m1_burstcount = 8'd1;
        ddram_waitrequest = 1'b0;
        ddram_readdata = '0;
        ddram_readdatavalid = 1'b0;

        // ---------------- reset values (a read held during reset) ----------
        cyc(); cyc();
        #1;
        check("rst_ddram_read",  {63'd0, ddram_read},     64'd0);
        check("rst_ddram_write", {63'd0, ddram_write},    64'd0);
        check("rst_m0_wait",     {63'd0, m0_waitrequest}, 64'd1);
        check("rst_m1_wait",     {63'd0, m1_waitrequest}, 64'd1);
        check("rst_m0_rdv",      {63'd0, m0_readdatavalid}, 64'd0);
        cyc();
        m0_read = 1'b0;
        reset   = 1'b0;

        // ---------------- single m0 read, burst 4 --------------------------
        cyc();
        m0_read = 1'b1; m0_address = 29'h100; m0_burstcount = 8'd4;
        #1;
        check("t1_ddram_read", {63'd0, ddram_read}, 64'd1);
        check("t1_addr",       64'(ddram_address), 64'h100);
        check("t1_bc",         64'(ddram_burstcount), 64'd4);
        check("t1_m0_wait",    {63'd0, m0_waitrequest}, 64'd0);
        check("t1_m1_wait",    {63'd0, m1_waitrequest}, 64'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
        cyc();
        m0_read = 1'b0;
        for (int i = 0; i < 4; i++) ret_beat(64'h1111_0000 + 64'(i));
        cyc();
        ddram_readdatavalid = 1'b1;
        #1;
        check("t1_tag_popped", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);

        // ---------------- m0 write burst 8, m1 read raised on beat 3 -------
        m1_address = 29'h200; m1_burstcount = 8'd1;
        m0_burstcount = 8'd8; m0_address = 29'h300;
        beat = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            m0_write          = wr_tab[i][1];
            ddram_waitrequest = wr_tab[i][0];
            m0_writedata      = 64'hA000 + 64'(beat);
            if (i == 2) m1_read = 1'b1;
            #1;
            check("t2_ddram_write", {63'd0, ddram_write}, {63'd0, wr_tab[i][1]});
            check("t2_m0_wait", {63'd0, m0_waitrequest},
                  {63'd0, !(wr_tab[i][1] && !wr_tab[i][0])});
            if (wr_tab[i][1]) check("t2_wdata", ddram_writedata, 64'hA000 + 64'(beat));
            if (i >= 2) begin
                check("t2_m1_locked", {63'd0, m1_waitrequest}, 64'd1);
                check("t2_no_read",   {63'd0, ddram_read},     64'd0);
            end
            if (wr_tab[i][1] && !wr_tab[i][0]) beat++;
        end
        cyc();
        m0_write = 1'b0;
        ddram_waitrequest = 1'b0;
        #1;
        check("t2_m1_fwd_read", {63'd0, ddram_read},     64'd1);
        check("t2_m1_wait",     {63'd0, m1_waitrequest}, 64'd0);
        check("t2_m1_addr",     64'(ddram_address),      64'h200);
        exp_q.push_back(1'b1);
        cyc();
        m1_read = 1'b0;
        ret_beat(64'hBEEF_0001);

        // ---------------- contention, 4 cycles -----------------------------
        m0_address = 29'h400; m1_address = 29'h500;
        m0_burstcount = 8'd1; m1_burstcount = 8'd1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_read = 1'b1; m1_read = 1'b1;
`ifdef DDRAM_ARB_RR_EN
            g = 1'(i % 2);
`else
            g = 1'b0;
`endif
            #1;
            check("t3_m0_wait", {63'd0, m0_waitrequest}, {63'd0, g != 1'b0});
            check("t3_m1_wait", {63'd0, m1_waitrequest}, {63'd0, g != 1'b1});
            check("t3_addr", 64'(ddram_address), g ? 64'h500 : 64'h400);
            exp_q.push_back(g);
        end
        cyc();
        m0_read = 1'b0; m1_read = 1'b0;
        for (int i = 0; i < 4; i++) ret_beat(64'hC000 + 64'(i));

        // ---------------- tag FIFO full ------------------------------------
        m0_burstcount = 8'd2;
        for (int i = 0; i < 4; i++) begin
            cyc();
            m0_read = 1'b1; m0_address = 29'h600 + 29'(i);
            #1;
            check("t4_fill_read", {63'd0, ddram_read}, 64'd1);
            exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        end
        cyc();
        m0_read = 1'b0;
        m1_read = 1'b1; m1_address = 29'h700; m1_burstcount = 8'd1;
        #1;
        check("t4_full_read", {63'd0, ddram_read},     64'd0);
        check("t4_full_wait", {63'd0, m1_waitrequest}, 64'd1);
        ret_beat(64'hD000);
        check("t4_beat1_stall", {63'd0, ddram_read}, 64'd0);
        ret_beat(64'hD001);
        check("t4_pop_same_cycle", {63'd0, ddram_read},     64'd0);
        check("t4_pop_same_wait",  {63'd0, m1_waitrequest}, 64'd1);
        cyc();
        #1;
        check("t4_unstall_read", {63'd0, ddram_read},     64'd1);
        check("t4_unstall_wait", {63'd0, m1_waitrequest}, 64'd0);
        check("t4_unstall_addr", 64'(ddram_address),      64'h700);
        exp_q.push_back(1'b1);
        cyc();
        m1_read = 1'b0;
        for (int i = 0; i < 7; i++) ret_beat(64'hD100 + 64'(i));

        // ---------------- interleaved tags m0(2), m1(1), m0(3) -------------
        cyc();
        m0_read = 1'b1; m0_burstcount = 8'd2;
        #1; check("t5_rd_a", {63'd0, ddram_read}, 64'd1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        cyc();
        m0_read = 1'b0; m1_read = 1'b1; m1_burstcount = 8'd1;
        #1; check("t5_rd_b", {63'd0, ddram_read}, 64'd1);
        exp_q.push_back(1'b1);
        cyc();
        m1_read = 1'b0; m0_read = 1'b1; m0_burstcount = 8'd3;
        #1; check("t5_rd_c", {63'd0, ddram_read}, 64'd1);
        repeat (3) exp_q.push_back(1'b0);
        cyc();
        m0_read = 1'b0;
        for (int i = 0; i < 6; i++) ret_beat(64'hE000 + 64'(i));

        // ---------------- burstcount 0 treated as 1 ------------------------
        cyc();
        m1_read = 1'b1; m1_burstcount = 8'd0;
        #1; check("t6_bc0_read", {63'd0, ddram_read}, 64'd1);
        exp_q.push_back(1'b1);
        cyc();
        m1_read = 1'b0;
        ret_beat(64'hF000);
        cyc();
        ddram_readdatavalid = 1'b1;
        #1;
        check("t6_bc0_one_beat", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
        cyc();
        m0_write = 1'b1; m0_burstcount = 8'd0;
        #1; check("t6_bc0_write", {63'd0, ddram_write}, 64'd1);
        cyc();
        m0_write = 1'b0; m1_write = 1'b1; m1_burstcount = 8'd1;
        #1; check("t6_bc0_no_lock", {63'd0, m1_waitrequest}, 64'd0);
        cyc();
        m1_write = 1'b0;

        // ---------------- reset during beat 2 of write burst 4 -------------
        cyc();
        m0_write = 1'b1; m0_burstcount = 8'd4;
        #1; check("t7_beat1", {63'd0, m0_waitrequest}, 64'd0);
        cyc();
        #1; check("t7_beat2", {63'd0, ddram_write}, 64'd1);
        reset = 1'b1;
        #1;
        check("t7_rst_write",   {63'd0, ddram_write},    64'd0);
        check("t7_rst_m0_wait", {63'd0, m0_waitrequest}, 64'd1);
        check("t7_rst_m1_wait", {63'd0, m1_waitrequest}, 64'd1);
        cyc();
        reset = 1'b0;
        m0_write = 1'b0;
        m1_write = 1'b1; m1_burstcount = 8'd1; m1_writedata = 64'h5A5A_1234;
        #1;
        check("t7_m1_write", {63'd0, ddram_write},    64'd1);
        check("t7_m1_wait",  {63'd0, m1_waitrequest}, 64'd0);
        check("t7_m1_wdata", ddram_writedata,         64'h5A5A_1234);
        cyc();
        m1_write = 1'b0;
        #1;
        check("t7_idle_write", {63'd0, ddram_write}, 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddram_arbiter.md
# ddram_arbiter

Two-port arbiter that shares the single 64-bit Avalon-MM burst master toward DDRAM (`ddram_*`) between two requesters: port 0 (CPU/cache memory path) and port 1 (video/HPS fill path). It forwards the winning master's command, holds ownership for the full length of write bursts, and uses an in-order tag FIFO to return read-data beats to the port that issued each read. It sits between the system interconnect and the top-level DDRAM bridge.

## Interface
- `AW`, 29: word address width, in 64-bit words.
- `BCW`, 8: burstcount width.
- `MAXPEND`, 4: maximum outstanding read commands. Must be a power of two, ≥2.
- `clk_sys`  in  1  single clock domain for all ports.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_address` / `m1_address`  in  AW  word address.
- `mN_read`, `mN_write`  in  1  command strobes; at most one is high per port.
- `mN_writedata`  in  64; `mN_byteenable`  in  8; `mN_burstcount`  in  BCW.
- `mN_waitrequest`  out  1  Avalon waitrequest for port N.
- `mN_readdata`  out  64; `mN_readdatavalid`  out  1.
- `ddram_address`  out  AW; `ddram_read`, `ddram_write`  out  1.
- `ddram_writedata`  out  64; `ddram_byteenable`  out  8; `ddram_burstcount`  out  BCW.
- `ddram_waitrequest`  in  1; `ddram_readdata`  in  64; `ddram_readdatavalid`  in  1.

## Operation
- States are IDLE and WRBURST.
- IDLE:
  - The winner is selected combinationally from the ports requesting (`read|write`).
  - The winner's address, data, byteenable, burstcount and strobes are forwarded to `ddram_*`.
  - The winner sees `waitrequest = ddram_waitrequest`. The loser sees `waitrequest = 1`.
- A read is accepted when `ddram_read & !ddram_waitrequest`. On acceptance, push {owner, burstcount} to the tag FIFO and stay in IDLE.
- Write accepted with burstcount >1: go to WRBURST, lock the owner, and load `beats_left = burstcount-1`.
  - Each accepted beat decrements `beats_left`.
  - Return to IDLE on the beat that leaves 0.
  - Burstcount 1 stays in IDLE.
- WRBURST:
  - Only the owner is forwarded. `ddram_read` is forced to 0. The other port is held in waitrequest.
  - Gaps where the owner deasserts `write` are legal and keep the lock.
- Read return:
  - The head tag routes `ddram_readdata`/`readdatavalid` to its owner.
  - A head-beat counter counts valid beats. On the beat equal to the head burstcount, the tag pops and the counter clears.
  - The non-owner's `readdatavalid` is 0. `readdata` is driven to both ports.
- Tag FIFO full:
  - A read from the winner is not forwarded: `ddram_read = 0`, and the winner's waitrequest is 1.
  - Writes still proceed.
  - A pop in the same cycle does not unblock a push; the read is retried next cycle.
- Burstcount 0 is treated as 1 for both beat counting and tag length.
- Arbitration (see Configuration): the priority pointer updates only when a command is accepted in IDLE.
- Reset mid-burst: state returns to IDLE, the FIFO empties, and counters clear. In-flight DDRAM responses after reset are the system's responsibility (reset is shared).

## Timing
- Command path master→`ddram_*` is combinational: zero added latency.
- Read data is combinational from `ddram_readdata` through the head-tag mux: zero added latency.
- One command is accepted per cycle maximum. Back-to-back reads from alternating ports are possible every cycle.
- Reset values:
  - `ddram_read = ddram_write = 0`.
  - `m0_waitrequest = m1_waitrequest = 1`.
  - `mN_readdatavalid = 0`.
  - State IDLE, FIFO empty, priority pointer = port 0.
- Outstanding-read limit: exactly MAXPEND accepted reads without any return; read number MAXPEND+1 stalls.

## Configuration
- `DDRAM_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - After a port wins an accepted command, the other port has priority on the next contended cycle.
- Not defined:
  - Fixed priority; port 0 always wins contention.
  - The pointer register is removed.

## Structure
- Package `ddram_arb_pkg`:
  - Tag struct `{owner:1, len:BCW}`.
  - State enum `{ST_IDLE, ST_WRBURST}`.
  - Port-ID constants `PORT_CPU = 0`, `PORT_VID = 1`.
- Sub-module `ddram_arb_tagfifo`: synchronous FIFO, depth MAXPEND, with full/empty/push/pop and a head output.

## Test plan
- Single m0 read, burstcount 4, DDRAM returns 4 beats → m0 sees 4 `readdatavalid`, m1 sees 0, and the tag pops after beat 4.
- m0 write burst 8 starts, m1 read raised during beat 3 → m1 waitrequest stays 1 until m0's 8th beat is accepted; the m1 read is forwarded the next cycle.
- m0 and m1 read simultaneously for 4 cycles with `DDRAM_ARB_RR_EN` → grants alternate 0,1,0,1. Without the macro → port 0 is granted all 4 cycles.
- 4 reads issued, no returns, 5th read presented → `ddram_read = 0` and requester waitrequest = 1. The stall clears the cycle after the first burst completes.
- Interleaved tags m0(len 2), m1(len 1), m0(len 3) → data beats are routed 0,0,1,0,0,0 in order.
- Reset asserted during beat 2 of a write burst 4 → `ddram_write = 0` and both waitrequests = 1 immediately. After release, a new m1 write is accepted in IDLE.
